// File: rtl/pgm_tx_sched.sv
// Transmit scheduler for the packet generator read path.
// A token bucket paces launches of generated packets towards the template reader, and every
// lat_interval-th launch can be flagged as a latency probe. The block stops on a run-time limit,
// on a packet-count limit, or when it is disabled. A launch that never sees pkt_done within
// TIMEOUT cycles raises a sticky error.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_wr/cfg_rd        register write / read strobes
//   cfg_addr, cfg_wdata  register address and write data
//   cfg_rdata            read data, registered, valid the cycle after cfg_rd
//   sched_start          one-cycle launch pulse to the template reader
//   sched_probe          qualifies sched_start: the launched packet is a probe
//   pkt_done             reader finished the last word of the current packet
//   in_rd_alf            downstream almost-full, holds off new launches
//   sched_busy           high in every state except IDLE and FIN
//   sched_err            sticky launch-timeout flag, cleared by soft_rst
module pgm_tx_sched #(
  parameter logic [15:0] TIMEOUT = 16'd4096,
  parameter int unsigned TOK_W   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        sched_start,
  output logic        sched_probe,
  input  logic        pkt_done,
  input  logic        in_rd_alf,
  output logic        sched_busy,
  output logic        sched_err
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StAccum  = 4'd1,
    StLaunch = 4'd2,
    StBusy   = 4'd3,
    StFin    = 4'd4
  } state_e;

  state_e state_q, state_d;

  // Configuration registers
  logic             enable_q, lat_en_q;
  logic [15:0]      rate_inc_q;
  logic [TOK_W-1:0] bucket_max_q;
  logic [10:0]      pkt_len_q;
  logic [15:0]      lat_interval_q;
  logic [31:0]      run_time_q, pkt_limit_q;

  // Run-time state
  logic [TOK_W-1:0] tokens_q, tokens_d;
  logic [31:0]      run_cnt_q, run_cnt_d;
  logic [31:0]      sent_q, sent_d;
  logic [31:0]      probe_cnt_q, probe_cnt_d;
  logic [15:0]      since_q, since_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             probe_q, probe_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             soft_rst;
  logic             stop;
  logic [TOK_W:0]   rate_ext, len_ext, tok_sum, tok_net;
  logic [TOK_W-1:0] tok_sat;
  logic [31:0]      run_inc;

  assign soft_rst = cfg_wr && (cfg_addr == 8'h00) && cfg_wdata[1];

  assign stop = ((run_time_q != 32'd0) && (run_cnt_q >= run_time_q)) ||
                ((pkt_limit_q != 32'd0) && (sent_q >= pkt_limit_q)) ||
                !enable_q;

  // Token arithmetic is one bit wider than the bucket so the add cannot wrap before saturation.
  assign rate_ext = {{(TOK_W - 15){1'b0}}, rate_inc_q};
  assign len_ext  = {{(TOK_W - 10){1'b0}}, pkt_len_q};
  assign tok_sum  = {1'b0, tokens_q} + rate_ext;
  assign run_inc  = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;

  always_comb begin
    tok_net = tok_sum;
    // Clamp at zero in case bucket_max was lowered under a pending launch.
    if (state_q == StLaunch) begin
      tok_net = (tok_sum >= len_ext) ? (tok_sum - len_ext) : '0;
    end
    tok_sat = (tok_net > {1'b0, bucket_max_q}) ? bucket_max_q : tok_net[TOK_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    tokens_d    = tokens_q;
    run_cnt_d   = run_cnt_q;
    sent_d      = sent_q;
    probe_cnt_d = probe_cnt_q;
    since_d     = since_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        tokens_d    = '0;
        run_cnt_d   = '0;
        sent_d      = '0;
        probe_cnt_d = '0;
        since_d     = '0;
        to_cnt_d    = '0;
        if (enable_q && (pkt_len_q != 11'd0)) state_d = StAccum;
      end
      StAccum: begin
        tokens_d  = tok_sat;
        run_cnt_d = run_inc;
        to_cnt_d  = '0;
        if (stop) begin
          state_d = StFin;
        end else if ((tokens_q >= len_ext[TOK_W-1:0]) && !in_rd_alf) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        tokens_d  = tok_sat;
        run_cnt_d = run_inc;
        sent_d    = sent_q + 32'd1;
        // The timeout counter measures cycles since the launch cycle itself.
        to_cnt_d  = to_cnt_q + 16'd1;
        if (probe_q) begin
          since_d     = '0;
          probe_cnt_d = probe_cnt_q + 32'd1;
        end else begin
          since_d = since_q + 16'd1;
        end
        state_d = StBusy;
      end
      StBusy: begin
        tokens_d  = tok_sat;
        run_cnt_d = run_inc;
        to_cnt_d  = to_cnt_q + 16'd1;
        if (pkt_done) begin
          state_d = StAccum;
        end else if (to_cnt_q >= TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StFin;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (soft_rst) begin
      state_d = StIdle;
      err_d   = 1'b0;
    end

    // Launch outputs are registered, so they are computed from the next state.
    start_d = (state_d == StLaunch);
    probe_d = start_d && lat_en_q && (lat_interval_q != 16'd0) && (since_q == lat_interval_q);
  end

  always_comb begin
    rdata_d = 32'hFFFF_FFFF;
    case (cfg_addr)
      8'h00:   rdata_d = {29'd0, lat_en_q, 1'b0, enable_q};
      8'h01:   rdata_d = {16'd0, rate_inc_q};
      8'h02:   rdata_d = {{(32 - TOK_W){1'b0}}, bucket_max_q};
      8'h03:   rdata_d = {21'd0, pkt_len_q};
      8'h04:   rdata_d = {16'd0, lat_interval_q};
      8'h05:   rdata_d = run_time_q;
      8'h06:   rdata_d = pkt_limit_q;
      8'h10:   rdata_d = {27'd0, err_q, state_q};
      8'h11:   rdata_d = sent_q;
      8'h12:   rdata_d = probe_cnt_q;
      8'h13:   rdata_d = {{(32 - TOK_W){1'b0}}, tokens_q};
      8'h14:   rdata_d = run_cnt_q;
      default: rdata_d = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q       <= 1'b0;
      lat_en_q       <= 1'b0;
      rate_inc_q     <= '0;
      bucket_max_q   <= '0;
      pkt_len_q      <= '0;
      lat_interval_q <= '0;
      run_time_q     <= '0;
      pkt_limit_q    <= '0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        8'h00: begin
          // soft_rst leaves the block disabled so it rests in IDLE afterwards.
          enable_q <= cfg_wdata[0] & ~cfg_wdata[1];
          lat_en_q <= cfg_wdata[2] & ~cfg_wdata[1];
        end
        8'h01: rate_inc_q   <= cfg_wdata[15:0];
        8'h02: bucket_max_q <= cfg_wdata[TOK_W-1:0];
        8'h03: begin
          if (state_q == StIdle) pkt_len_q <= cfg_wdata[10:0];
        end
        8'h04: lat_interval_q <= cfg_wdata[15:0];
        8'h05: run_time_q     <= cfg_wdata;
        8'h06: pkt_limit_q    <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tokens_q    <= '0;
      run_cnt_q   <= '0;
      sent_q      <= '0;
      probe_cnt_q <= '0;
      since_q     <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      probe_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      tokens_q    <= tokens_d;
      run_cnt_q   <= run_cnt_d;
      sent_q      <= sent_d;
      probe_cnt_q <= probe_cnt_d;
      since_q     <= since_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      start_q     <= start_d;
      probe_q     <= probe_d;
      if (cfg_rd) rdata_q <= rdata_d;
    end
  end

  assign cfg_rdata   = rdata_q;
  assign sched_start = start_q;
  assign sched_probe = probe_q;
  assign sched_err   = err_q;
  assign sched_busy  = (state_q != StIdle) && (state_q != StFin);

endmodule

// File: tb/tb_pgm_tx_sched.sv
// Bench for pgm_tx_sched: register table plus hand-written pacing, saturation, probe,
// run-time stop, timeout, backpressure and asynchronous reset sequences.
module tb_pgm_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic [7:0]  cfg_addr = 8'h00;
  logic [31:0] cfg_wdata = 32'h0;
  logic [31:0] cfg_rdata;
  logic        sched_start, sched_probe, sched_busy, sched_err;
  logic        pkt_done = 1'b0;
  logic        in_rd_alf = 1'b0;

  pgm_tx_sched #(
    .TIMEOUT (16'd16),
    .TOK_W   (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wr      (cfg_wr),
    .cfg_rd      (cfg_rd),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .sched_start (sched_start),
    .sched_probe (sched_probe),
    .pkt_done    (pkt_done),
    .in_rd_alf   (in_rd_alf),
    .sched_busy  (sched_busy),
    .sched_err   (sched_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          ge;
  } rd_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          do_wr;
  } vec_t;

  int      n_checks = 0;
  int      n_pass = 0;
  int      cyc = 0;
  bit      done_en = 1'b0;
  bit      rd_vld = 1'b0;
  int      start_cyc[$];
  bit      probe_q[$];
  rd_exp_t rd_q[$];

  task automatic report(input string name, input bit ok, input logic [31:0] act,
                        input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= cfg_rd;
  end

  // Monitor: read-data scoreboard, probe-flag scoreboard and pkt_done responder.
  initial begin
    int      dcnt;
    bit      pe;
    rd_exp_t e;
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (rd_vld) begin
        if (rd_q.size() == 0) begin
          report("rd_unexpected", 1'b0, cfg_rdata, 32'h0);
        end else begin
          e = rd_q.pop_front();
          report(e.name, e.ge ? (cfg_rdata >= e.exp) : (cfg_rdata == e.exp), cfg_rdata, e.exp);
        end
      end
      if (sched_start) begin
        start_cyc.push_back(cyc);
        pe = (probe_q.size() != 0) ? probe_q.pop_front() : 1'b0;
        report("probe_flag", sched_probe == pe, {31'd0, sched_probe}, {31'd0, pe});
      end else if (sched_probe) begin
        report("probe_without_start", 1'b0, 32'd1, 32'd0);
      end
      pkt_done = 1'b0;
      if (dcnt != 0) begin
        dcnt--;
        if (dcnt == 0) pkt_done = 1'b1;
      end
      if (sched_start && done_en) dcnt = 2;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp,
                    input bit ge = 1'b0);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    e.ge   = ge;
    rd_q.push_back(e);
    cfg_rd   = 1'b1;
    cfg_addr = a;
    @(negedge clk);
    cfg_rd = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int budget);
    int n = 0;
    while (sched_busy && n < budget) begin
      tick();
      n++;
    end
    report(name, !sched_busy, {31'd0, sched_busy}, 32'd0);
  endtask

  vec_t        vecs[12];
  int          w, r, s, e, n;
  logic [7:0]  pat;
  logic [7:0]  ra;

  initial begin
    // Reset state
    tick(2);
    report("rst_start", sched_start == 1'b0, {31'd0, sched_start}, 32'd0);
    report("rst_probe", sched_probe == 1'b0, {31'd0, sched_probe}, 32'd0);
    report("rst_busy", sched_busy == 1'b0, {31'd0, sched_busy}, 32'd0);
    report("rst_err", sched_err == 1'b0, {31'd0, sched_err}, 32'd0);
    report("rst_rdata", cfg_rdata == 32'h0, cfg_rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      ra = (i < 7) ? 8'(i) : 8'(8'h10 + i - 7);
      rd($sformatf("rst_reg_%02h", ra), ra, 32'h0);
    end

    // Register write/readback table
    vecs[0]  = '{8'h01, 32'hABCD_1234, 32'h0000_1234, 1'b1};
    vecs[1]  = '{8'h02, 32'hFFFF_FFFF, 32'h00FF_FFFF, 1'b1};
    vecs[2]  = '{8'h03, 32'h0000_FFFF, 32'h0000_07FF, 1'b1};
    vecs[3]  = '{8'h04, 32'h0001_2345, 32'h0000_2345, 1'b1};
    vecs[4]  = '{8'h05, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{8'h06, 32'h0000_0007, 32'h0000_0007, 1'b1};
    vecs[6]  = '{8'h00, 32'h0000_0004, 32'h0000_0004, 1'b1};
    vecs[7]  = '{8'h20, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{8'h07, 32'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{8'h10, 32'h0, 32'h0000_0000, 1'b0};
    vecs[10] = '{8'h13, 32'h0, 32'h0000_0000, 1'b0};
    vecs[11] = '{8'hFF, 32'h0, 32'hFFFF_FFFF, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd($sformatf("tbl_%0d_reg_%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end

    // Token pacing: first start 9 cycles into ACCUM, then one start per 8 cycles
    wr(8'h00, 32'h2);
    wr(8'h01, 32'd8);
    wr(8'h02, 32'd256);
    wr(8'h03, 32'd64);
    wr(8'h04, 32'd0);
    wr(8'h05, 32'd0);
    wr(8'h06, 32'd4);
    done_en = 1'b1;
    start_cyc.delete();
    w = cyc;
    wr(8'h00, 32'h1);
    tick(2);
    wait_fin("pace_fin", 200);
    report("pace_nstart", start_cyc.size() == 4, 32'(start_cyc.size()), 32'd4);
    for (int i = 0; i < start_cyc.size() && i < 4; i++) begin
      report($sformatf("pace_start_%0d", i), start_cyc[i] == w + 11 + 8 * i,
             32'(start_cyc[i] - w), 32'(11 + 8 * i));
    end
    rd("pace_status", 8'h10, 32'h4);
    rd("pace_sent", 8'h11, 32'd4);
    wr(8'h03, 32'd99);
    rd("pkt_len_locked_fin", 8'h03, 32'd64);

    // Saturation: tokens pinned at bucket_max, never enough for a packet
    wr(8'h00, 32'h2);
    wr(8'h01, 32'd100);
    wr(8'h02, 32'd150);
    wr(8'h03, 32'd200);
    wr(8'h06, 32'd0);
    start_cyc.delete();
    wr(8'h00, 32'h1);
    tick(20);
    rd("sat_tokens", 8'h13, 32'd150);
    report("sat_nostart", start_cyc.size() == 0, 32'(start_cyc.size()), 32'd0);
    wr(8'h03, 32'd5);
    rd("pkt_len_locked_run", 8'h03, 32'd200);
    rd("sat_status", 8'h10, 32'h1);
    wr(8'h00, 32'h0);
    tick(2);
    rd("disable_status", 8'h10, 32'h4);
    wr(8'h00, 32'h2);
    rd("srst_status", 8'h10, 32'h0);
    rd("cfg_retained", 8'h03, 32'd200);

    // Probe insertion every 4th packet
    wr(8'h01, 32'd64);
    wr(8'h02, 32'd256);
    wr(8'h03, 32'd16);
    wr(8'h04, 32'd3);
    wr(8'h06, 32'd8);
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) probe_q.push_back(pat[i]);
    start_cyc.delete();
    wr(8'h00, 32'h5);
    tick(2);
    rd("ctrl_rb", 8'h00, 32'h5);
    wait_fin("probe_fin", 500);
    report("probe_nstart", start_cyc.size() == 8, 32'(start_cyc.size()), 32'd8);
    report("probe_q_empty", probe_q.size() == 0, 32'(probe_q.size()), 32'd0);
    rd("probe_cnt", 8'h12, 32'd2);
    rd("probe_sent", 8'h11, 32'd8);
    rd("probe_status", 8'h10, 32'h4);

    // Run-time stop
    wr(8'h00, 32'h2);
    wr(8'h01, 32'd1000);
    wr(8'h02, 32'd5000);
    wr(8'h03, 32'd10);
    wr(8'h04, 32'd0);
    wr(8'h06, 32'd0);
    wr(8'h05, 32'd100);
    wr(8'h00, 32'h1);
    tick(2);
    wait_fin("rt_fin", 300);
    rd("rt_run_cnt", 8'h14, 32'd100, 1'b1);
    rd("rt_status", 8'h10, 32'h4);
    n = start_cyc.size();
    tick(10);
    report("rt_no_more_start", start_cyc.size() == n, 32'(start_cyc.size()), 32'(n));

    // Launch timeout: no pkt_done ever returned
    wr(8'h00, 32'h2);
    wr(8'h05, 32'd0);
    wr(8'h01, 32'd64);
    wr(8'h02, 32'd256);
    wr(8'h03, 32'd16);
    done_en = 1'b0;
    start_cyc.delete();
    wr(8'h00, 32'h1);
    n = 0;
    while (!sched_err && n < 100) begin
      tick();
      n++;
    end
    e = cyc;
    report("to_err_set", sched_err == 1'b1, {31'd0, sched_err}, 32'd1);
    s = (start_cyc.size() != 0) ? start_cyc[0] : -1000;
    report("to_latency", (e - s) == 16, 32'(e - s), 32'd16);
    report("to_busy_low", sched_busy == 1'b0, {31'd0, sched_busy}, 32'd0);
    rd("to_status", 8'h10, 32'h14);
    wr(8'h00, 32'h2);
    report("to_err_cleared", sched_err == 1'b0, {31'd0, sched_err}, 32'd0);
    rd("to_srst_status", 8'h10, 32'h0);

    // Backpressure, then asynchronous reset while BUSY
    in_rd_alf = 1'b1;
    start_cyc.delete();
    wr(8'h00, 32'h1);
    tick(20);
    report("bp_nostart", start_cyc.size() == 0, 32'(start_cyc.size()), 32'd0);
    rd("bp_tokens", 8'h13, 32'd256);
    rd("bp_status", 8'h10, 32'h1);
    r = cyc;
    in_rd_alf = 1'b0;
    tick(3);
    report("bp_nstart", start_cyc.size() == 1, 32'(start_cyc.size()), 32'd1);
    s = (start_cyc.size() != 0) ? start_cyc[0] : -1000;
    report("bp_start_cycle", s == r + 1, 32'(s - r), 32'd1);
    report("bp_busy", sched_busy == 1'b1, {31'd0, sched_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    report("arst_busy", sched_busy == 1'b0, {31'd0, sched_busy}, 32'd0);
    report("arst_start", sched_start == 1'b0, {31'd0, sched_start}, 32'd0);
    report("arst_probe", sched_probe == 1'b0, {31'd0, sched_probe}, 32'd0);
    report("arst_err", sched_err == 1'b0, {31'd0, sched_err}, 32'd0);
    report("arst_rdata", cfg_rdata == 32'h0, cfg_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd("arst_status", 8'h10, 32'h0);
    rd("arst_tokens", 8'h13, 32'h0);
    rd("arst_rate", 8'h01, 32'h0);

    tick(2);
    report("rd_queue_drained", rd_q.size() == 0, 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
